// File: rtl/mux_cmd_ctrl.sv
// Host command controller for the 4-in/16-out pin mux: parses UART command bytes,
// holds enable mask and pin map, streams reads back. MUX_CMD_ACK_EN adds ACK/NAK replies.
module mux_cmd_ctrl #(
  parameter int unsigned RX_TIMEOUT   = 2048,
  parameter logic [15:0] ENABLE_RESET = 16'hAA55,
  parameter logic [31:0] PINMAP_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [15:0] enabled_out,
  output logic [31:0] selectors
);

  localparam int unsigned TW = $clog2(RX_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ARGS,
    S_TX_LOAD,
    S_TX_WAIT_BUSY,
`ifdef MUX_CMD_ACK_EN
    S_ACK,
`endif
    S_TX_WAIT_DONE
  } state_t;

  state_t        state;
  logic [31:0]   shift_buf;
  logic [31:0]   stage;
  logic [2:0]    byte_cnt;
  logic          is_pinmap;
  logic [TW-1:0] tmo_cnt;
`ifdef MUX_CMD_ACK_EN
  logic [7:0]    ack_byte;
`endif

  logic [31:0] snap;
  logic [2:0]  snap_n;

  always_comb begin
    snap   = {enabled_out, 16'h0000};
    snap_n = 3'd2;
    if (rx_data == 8'h02) begin
      snap   = selectors;
      snap_n = 3'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      shift_buf   <= '0;
      stage       <= '0;
      byte_cnt    <= '0;
      is_pinmap   <= 1'b0;
      tmo_cnt     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'hFF;
      enabled_out <= ENABLE_RESET;
      selectors   <= PINMAP_RESET;
`ifdef MUX_CMD_ACK_EN
      ack_byte    <= 8'h06;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              8'h01, 8'h02: begin
                // Launch the first byte on the command edge when the UART is already idle.
                if (tx_done) begin
                  tx_data   <= snap[31:24];
                  tx_start  <= 1'b1;
                  shift_buf <= {snap[23:0], 8'h00};
                  byte_cnt  <= snap_n - 3'd1;
                  state     <= S_TX_WAIT_BUSY;
                end else begin
                  shift_buf <= snap;
                  byte_cnt  <= snap_n;
                  state     <= S_TX_LOAD;
                end
              end
              8'h03, 8'h04: begin
                stage     <= '0;
                tmo_cnt   <= '0;
                is_pinmap <= (rx_data == 8'h04);
                byte_cnt  <= (rx_data == 8'h04) ? 3'd4 : 3'd2;
                state     <= S_RX_ARGS;
              end
              default: state <= S_IDLE;
            endcase
          end
        end

        S_RX_ARGS: begin
          if (tmo_cnt == TMO_LAST) begin
            stage <= '0;
`ifdef MUX_CMD_ACK_EN
            ack_byte <= 8'h15;
            state    <= S_ACK;
`else
            state    <= S_IDLE;
`endif
          end else if (rx_valid) begin
            stage    <= {stage[23:0], rx_data};
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt - 3'd1;
            if (byte_cnt == 3'd1) begin
              if (is_pinmap) selectors   <= {stage[23:0], rx_data};
              else           enabled_out <= {stage[7:0], rx_data};
`ifdef MUX_CMD_ACK_EN
              ack_byte <= 8'h06;
              state    <= S_ACK;
`else
              state    <= S_IDLE;
`endif
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

`ifdef MUX_CMD_ACK_EN
        S_ACK: begin
          shift_buf <= {ack_byte, 24'h000000};
          byte_cnt  <= 3'd1;
          state     <= S_TX_LOAD;
        end
`endif

        S_TX_LOAD: begin
          if (tx_done) begin
            tx_data   <= shift_buf[31:24];
            tx_start  <= 1'b1;
            shift_buf <= {shift_buf[23:0], 8'h00};
            byte_cnt  <= byte_cnt - 3'd1;
            state     <= S_TX_WAIT_BUSY;
          end
        end

        S_TX_WAIT_BUSY: begin
          if (!tx_done) state <= S_TX_WAIT_DONE;
        end

        S_TX_WAIT_DONE: begin
          if (tx_done) state <= (byte_cnt != 3'd0) ? S_TX_LOAD : S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
